// File: rtl/issue_pkg.sv
// Shared types and opcode classification for the dual-issue queue.
package issue_pkg;

  // ALU control encodings produced by the decoder.
  localparam logic [7:0] AND_CONTROL   = 8'b0010_0100;
  localparam logic [7:0] OR_CONTROL    = 8'b0010_0101;
  localparam logic [7:0] XOR_CONTROL   = 8'b0010_0110;
  localparam logic [7:0] ADDU_CONTROL  = 8'b0010_0001;
  localparam logic [7:0] SUBU_CONTROL  = 8'b0010_0011;
  localparam logic [7:0] SLT_CONTROL   = 8'b0010_1010;
  localparam logic [7:0] MFHI_CONTROL  = 8'b0001_0000;
  localparam logic [7:0] MTHI_CONTROL  = 8'b0001_0001;
  localparam logic [7:0] MFLO_CONTROL  = 8'b0001_0010;
  localparam logic [7:0] MTLO_CONTROL  = 8'b0001_0011;
  localparam logic [7:0] MULT_CONTROL  = 8'b0001_1000;
  localparam logic [7:0] MULTU_CONTROL = 8'b0001_1001;
  localparam logic [7:0] DIV_CONTROL   = 8'b0001_1010;
  localparam logic [7:0] DIVU_CONTROL  = 8'b0001_1011;
  localparam logic [7:0] MADD_CONTROL  = 8'b0110_0000;
  localparam logic [7:0] MADDU_CONTROL = 8'b0110_0001;
  localparam logic [7:0] MUL_CONTROL   = 8'b0110_0010;
  localparam logic [7:0] MSUB_CONTROL  = 8'b0110_0100;
  localparam logic [7:0] MSUBU_CONTROL = 8'b0110_0101;

  // One decoded instruction as it travels through the queue.
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  alucontrol;
    logic [4:0]  dst;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
  } issue_entry_t;

  // Ops that occupy the shared multiply/divide unit.
  function automatic logic is_md(input logic [7:0] ctrl);
    case (ctrl)
      MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL,
      MADD_CONTROL, MADDU_CONTROL, MSUB_CONTROL, MSUBU_CONTROL,
      MUL_CONTROL: is_md = 1'b1;
      default:     is_md = 1'b0;
    endcase
  endfunction

  // Ops that write HI/LO (MUL writes a GPR only).
  function automatic logic is_hilo_wr(input logic [7:0] ctrl);
    case (ctrl)
      MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL,
      MADD_CONTROL, MADDU_CONTROL, MSUB_CONTROL, MSUBU_CONTROL,
      MTHI_CONTROL, MTLO_CONTROL: is_hilo_wr = 1'b1;
      default:                    is_hilo_wr = 1'b0;
    endcase
  endfunction

  // Ops that read HI/LO, including the accumulating multiplies.
  function automatic logic is_hilo_rd(input logic [7:0] ctrl);
    case (ctrl)
      MFHI_CONTROL, MFLO_CONTROL, MADD_CONTROL, MADDU_CONTROL,
      MSUB_CONTROL, MSUBU_CONTROL: is_hilo_rd = 1'b1;
      default:                     is_hilo_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Decides whether the oldest one or two queue entries may issue this cycle.
module issue_pair_check
  import issue_pkg::*;
#(
  parameter int CW = 4
) (
  input  issue_entry_t  head0,
  input  issue_entry_t  head1,
  input  logic [CW-1:0] count,
  output logic          issue0,
  output logic          issue1
);

  logic md_conflict;
  logic hilo_conflict;
  logic raw_conflict;

  // Fields that play no part in pairing are folded here so they are visibly consumed.
  logic unused_fields;
  assign unused_fields = ^{head0.pc, head0.src_a, head0.src_b, head1.pc, head1.dst};

  // Slot 1 only takes the second entry when the execute pair can run both at once.
  always_comb begin
    md_conflict   = is_md(head0.alucontrol) && is_md(head1.alucontrol);
    hilo_conflict = is_hilo_wr(head0.alucontrol) && is_hilo_rd(head1.alucontrol);
    raw_conflict  = (head0.dst != 5'd0) &&
                    ((head0.dst == head1.src_a) || (head0.dst == head1.src_b));
    issue0        = (count != '0);
    issue1        = (count >= CW'(2)) && !md_conflict && !hilo_conflict && !raw_conflict;
  end

endmodule

// File: rtl/dual_issue_queue.sv
// Circular instruction buffer feeding two registered issue slots.
module dual_issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid0,
  input  logic                   push_valid1,
  input  issue_entry_t           push_entry0,
  input  issue_entry_t           push_entry1,
  output logic                   push_ready,
  input  logic                   stall_masterE,
  input  logic                   flush_masterE,
  output logic                   issue_valid0,
  output logic                   issue_valid1,
  output issue_entry_t           issue_entry0,
  output issue_entry_t           issue_entry1,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  issue_entry_t  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_plus1;
  logic [PW-1:0] tail_plus1;
  logic [1:0]    push_count;
  logic [1:0]    pop_count;
  logic          can_issue0;
  logic          can_issue1;
  issue_entry_t  head0;
  issue_entry_t  head1;

  assign head_plus1 = head + PW'(1);
  assign tail_plus1 = tail + PW'(1);
  assign head0      = mem[head];
  assign head1      = mem[head_plus1];
  assign push_ready = (count <= CW'(DEPTH - 2));

  issue_pair_check #(
    .CW(CW)
  ) u_pair_check (
    .head0  (head0),
    .head1  (head1),
    .count  (count),
    .issue0 (can_issue0),
    .issue1 (can_issue1)
  );

  // Work out how many entries enter and leave the queue on the coming edge.
  always_comb begin
    push_count = 2'd0;
    pop_count  = 2'd0;
    if (push_ready && push_valid0) begin
      push_count = push_valid1 ? 2'd2 : 2'd1;
    end
    if (!stall_masterE && !flush_masterE) begin
      if (can_issue1) begin
        pop_count = 2'd2;
      end else if (can_issue0) begin
        pop_count = 2'd1;
      end
    end
  end

  // Storage writes; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (!flush_masterE && (push_count != 2'd0)) begin
      mem[tail] <= push_entry0;
      if (push_count == 2'd2) begin
        mem[tail_plus1] <= push_entry1;
      end
    end
  end

  // Pointers and occupancy; flush empties the queue and drops same-cycle pushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_masterE) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_count);
      tail  <= tail + PW'(push_count);
      count <= count + CW'(push_count) - CW'(pop_count);
    end
  end

  // Issue slots reload every unstalled cycle; a slot with nothing to issue goes empty and zeroed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid0 <= 1'b0;
      issue_valid1 <= 1'b0;
      issue_entry0 <= '0;
      issue_entry1 <= '0;
    end else if (flush_masterE) begin
      issue_valid0 <= 1'b0;
      issue_valid1 <= 1'b0;
      issue_entry0 <= '0;
      issue_entry1 <= '0;
    end else if (!stall_masterE) begin
      issue_valid0 <= can_issue0;
      issue_valid1 <= can_issue1;
      issue_entry0 <= can_issue0 ? head0 : '0;
      issue_entry1 <= can_issue1 ? head1 : '0;
    end
  end

  // Pushing while the queue has not offered room is a protocol violation by the decoder.
  a_push_needs_room : assert property (@(posedge clk) disable iff (!rst)
    push_valid0 |-> push_ready);

endmodule
